// File: rtl/systolic_feed_ctrl.sv
// Operand feed sequencer for an N x N systolic array: clears the accumulators,
// drives skewed per-lane shift enables, drains the array and signals completion.
module systolic_feed_ctrl #(
  parameter int N            = 4,
  parameter int K_MAX        = 16,
  parameter int DRAIN_CYCLES = 4,
  parameter int KW           = $clog2(K_MAX + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start_i,
  input  logic [KW-1:0] k_len_i,
  input  logic          stall_i,
  output logic [N-1:0]  shift_o,
  output logic          pe_en_o,
  output logic          acc_clr_o,
  output logic          busy_o,
  output logic          done_o
);

  localparam int TW  = $clog2(K_MAX + N);
  localparam int TPW = TW + 1;
  localparam int DW  = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] t_q, t_d;
  logic [DW-1:0] d_q, d_d;
  logic [KW-1:0] k_q, k_d;

  logic [KW-1:0] k_sat;
  logic          feed_last;
  logic          drain_last;

  assign k_sat      = (k_len_i > KW'(K_MAX)) ? KW'(K_MAX) : k_len_i;
  assign feed_last  = (t_q == TW'(k_q) + TW'(N - 2));
  assign drain_last = (d_q == DW'(DRAIN_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      t_q     <= '0;
      d_q     <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      d_q     <= d_d;
      k_q     <= k_d;
    end
  end

  // Counters only advance on unstalled edges, so a stall simply freezes the sequence.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    d_d     = d_q;
    k_d     = k_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          k_d = k_sat;
          t_d = '0;
          state_d = (k_sat == '0) ? S_DONE : S_CLR;
        end
      end
      S_CLR: state_d = S_FEED;
      S_FEED: begin
        if (!stall_i) begin
          if (feed_last) begin
            state_d = S_DRAIN;
            d_d     = '0;
          end else begin
            t_d = t_q + TW'(1);
          end
        end
      end
      S_DRAIN: begin
        if (!stall_i) begin
          if (drain_last) state_d = S_DONE;
          else            d_d = d_q + DW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    shift_o   = '0;
    pe_en_o   = 1'b0;
    acc_clr_o = (state_q == S_CLR);
    busy_o    = (state_q != S_IDLE);
    done_o    = (state_q == S_DONE);
    if (state_q == S_FEED && !stall_i) begin
      pe_en_o = 1'b1;
      // Lane i is live during the K-cycle window starting i cycles into FEED.
      for (int i = 0; i < N; i++) begin
        shift_o[i] = (t_q >= TW'(i)) && ({1'b0, t_q} < TPW'(i) + TPW'(k_q));
      end
    end
    if (state_q == S_DRAIN && !stall_i) pe_en_o = 1'b1;
  end

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Bench for systolic_feed_ctrl: directed scenarios plus random operations checked
// cycle by cycle against a queue of expected output vectors built per operation.
module tb_systolic_feed_ctrl;

  localparam int N     = 4;
  localparam int K_MAX = 16;
  localparam int DC    = 4;
  localparam int KW    = $clog2(K_MAX + 1);
  localparam int W     = N + 4;

  // clock/reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n = 1'b0;
  logic          start_i = 1'b0;
  logic [KW-1:0] k_len_i = '0;
  logic          stall_i = 1'b0;
  logic [N-1:0]  shift_o;
  logic          pe_en_o;
  logic          acc_clr_o;
  logic          busy_o;
  logic          done_o;

  systolic_feed_ctrl #(.N(N), .K_MAX(K_MAX), .DRAIN_CYCLES(DC)) dut (
    .clk(clk), .reset_n(reset_n), .start_i(start_i), .k_len_i(k_len_i),
    .stall_i(stall_i), .shift_o(shift_o), .pe_en_o(pe_en_o),
    .acc_clr_o(acc_clr_o), .busy_o(busy_o), .done_o(done_o)
  );

  // scoreboard: one entry per unstalled cycle of the current operation
  // vector layout {shift[N-1:0], pe_en, acc_clr, busy, done}
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int last_lat = -1;
  int done_cnt = 0;
  int exp_k = 0;
  int lane_cnt[N];
  bit known = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic build_op(input int k);
    logic [W-1:0] v;
    exp_q.delete();
    if (k > 0) begin
      exp_q.push_back(W'(4'b0110));
      for (int u = 0; u < k + N - 1; u++) begin
        v = W'(4'b1010);
        for (int i = 0; i < N; i++) v[4 + i] = (u >= i) && (u < i + k);
        exp_q.push_back(v);
      end
      for (int j = 0; j < DC; j++) exp_q.push_back(W'(4'b1010));
    end
    exp_q.push_back(W'(4'b0011));
  endtask

  // driver task: one clock cycle with the given inputs
  task automatic tick(input logic st, input int kl, input logic sl, input logic rn);
    logic [W-1:0] expv, obs;
    int ks;
    start_i = st;
    k_len_i = KW'(kl);
    stall_i = sl;
    reset_n = rn;
    #1;
    if (exp_q.size() == 0)                    expv = '0;
    else if (sl && exp_q[0][3])               expv = W'(4'b0010);
    else                                      expv = exp_q[0];
    obs = {shift_o, pe_en_o, acc_clr_o, busy_o, done_o};
    if (known) begin
      check("outputs", 32'(obs), 32'(expv));
      for (int i = 0; i < N; i++) if (shift_o[i]) lane_cnt[i]++;
      if (done_o) begin
        done_cnt++;
        last_lat = cyc - start_cyc;
      end
      if (expv[0]) for (int i = 0; i < N; i++) check("lane_shifts", 32'(lane_cnt[i]), 32'(exp_k));
    end
    // reference update at the coming edge
    if (!rn) begin
      exp_q.delete();
      known = 1;
      for (int i = 0; i < N; i++) lane_cnt[i] = 0;
    end else if (exp_q.size() == 0) begin
      if (st) begin
        ks = (kl > K_MAX) ? K_MAX : kl;
        exp_k = ks;
        start_cyc = cyc;
        for (int i = 0; i < N; i++) lane_cnt[i] = 0;
        build_op(ks);
      end
    end else if (!(sl && exp_q[0][3])) begin
      void'(exp_q.pop_front());
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 1);
  endtask

  initial begin
    int k, guard;
    logic sl;
    @(posedge clk);
    #1;
    // reset then idle
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    idle(10);
    check("busy_after_reset", 32'(busy_o), 32'd0);

    // basic run K=3
    tick(1, 3, 0, 1);
    idle(14);
    check("basic_done_latency", 32'(last_lat), 32'd12);

    // stall for 3 cycles after three feed shifts (pattern resumes with 1110)
    tick(1, 3, 0, 1);
    tick(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) tick(0, 0, 1, 1);
    idle(14);
    check("stall_done_latency", 32'(last_lat), 32'd15);

    // K = 0 and K saturation
    tick(1, 0, 0, 1);
    idle(3);
    check("k0_done_latency", 32'(last_lat), 32'd1);
    tick(1, 31, 0, 1);
    idle(30);

    // mid-op reset at FEED t=2, then a fresh full run
    done_cnt = 0;
    tick(1, 3, 0, 1);
    idle(3);
    tick(0, 0, 0, 0);
    idle(14);
    check("reset_no_done", 32'(done_cnt), 32'd0);
    tick(1, 3, 0, 1);
    idle(14);
    check("post_reset_latency", 32'(last_lat), 32'd12);

    // start held high through a run: one done in the window, restart right after
    done_cnt = 0;
    for (int i = 0; i < 14; i++) tick(1, 3, 0, 1);
    check("held_start_single_done", 32'(done_cnt), 32'd1);
    check("held_start_restart_clr", 32'(acc_clr_o), 32'd1);
    idle(16);

    // randomized operations with random stalls and stray starts
    for (int op = 0; op < 25; op++) begin
      k = $urandom_range(0, 20);
      tick(1, k, 1'($urandom_range(0, 1)), 1);
      guard = 0;
      while (exp_q.size() > 0 && guard < 300) begin
        sl = ($urandom_range(0, 3) == 0);
        tick(1'($urandom_range(0, 1)), $urandom_range(0, 31), sl, 1);
        guard++;
      end
      check("random_op_terminates", 32'(exp_q.size()), 32'd0);
      idle($urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
